// File: rtl/cpu_pkg.sv
// CPU-wide shared definitions: sequencer state encodings, register-file geometry
// and the writeback request record used by register-file write paths.
package cpu_pkg;

   localparam logic [2:0] STATE_IDLE  = 3'b000;
   localparam logic [2:0] STATE_FETCH = 3'b001;
   localparam logic [2:0] STATE_EXEC  = 3'b010;
   localparam logic [2:0] STATE_WB    = 3'b011;
   localparam logic [2:0] STATE_MEM   = 3'b100;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 64;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wr_req_t;

   typedef enum logic {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } hold_state_t;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus (requester side) and register-file write port
// (commit side) of the register-file write arbiter.
interface regfile_write_arbiter_if
   import cpu_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = REG_DATA_W,
   parameter int ADDR_W  = REG_ADDR_W
);
   localparam int ID_W = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;

   logic                      write_en;
   logic [ADDR_W-1:0]         write_reg;
   logic [DATA_W-1:0]         write_data;
   logic [ID_W-1:0]           grant_id;

   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, write_en, write_reg, write_data, grant_id
   );

   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, write_en, write_reg, write_data, grant_id
   );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Generic combinational round-robin picker: first set req bit at or after ptr,
// wrapping at NUM_REQ-1; zero latency, no backpressure of its own.
module rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   int j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         j = int'(ptr) + off;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin shares the register-file write port via a one-entry holding register;
// accept-to-commit >=1 cycle (commits in WB state), requesters stall while it is full.
module regfile_write_arbiter
   import cpu_pkg::*;
#(
   parameter int         NUM_REQ  = 3,
   parameter int         DATA_W   = REG_DATA_W,
   parameter int         ADDR_W   = REG_ADDR_W,
   parameter logic [2:0] WB_STATE = STATE_WB
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [2:0]              state,
   regfile_write_arbiter_if.slave  bus,
   input  logic [ADDR_W-1:0]       query_addr,
   output logic                    query_pending
);

   localparam int ID_W = id_width(NUM_REQ);

   hold_state_t                cur;
   hold_state_t                nxt;
   wr_req_t [NUM_REQ-1:0]      req_vec;
   wr_req_t                    hold;
   logic [ID_W-1:0]            hold_id;
   logic [ID_W-1:0]            rr_ptr;
   logic [ID_W-1:0]            ptr_nxt;

   logic [NUM_REQ-1:0]         win_onehot;
   logic [ID_W-1:0]            win_idx;
   logic                       win_any;
   logic                       full;
   logic                       drain;
   logic                       slot_free;
   logic                       accept;

   always_comb begin
      req_vec = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_vec[i].addr = bus.req_addr[i*ADDR_W +: ADDR_W];
         req_vec[i].data = bus.req_data[i*DATA_W +: DATA_W];
      end
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (win_onehot),
      .idx   (win_idx),
      .any   (win_any)
   );

   always_comb begin
      full      = (cur == HOLD_FULL);
      drain     = full && (state == WB_STATE);
      slot_free = !full || drain;
      // Gating with reset keeps req_ready low while reset is asserted.
      accept    = reset && slot_free && win_any;
      ptr_nxt   = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);

      nxt = cur;
      if (accept) begin
         nxt = HOLD_FULL;
      end else if (drain) begin
         nxt = HOLD_EMPTY;
      end

      bus.req_ready  = accept ? win_onehot : '0;
      bus.write_en   = drain;
      bus.write_reg  = full ? hold.addr : '0;
      bus.write_data = full ? hold.data : '0;
      bus.grant_id   = full ? hold_id   : '0;
      query_pending  = full && (hold.addr == query_addr);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur <= HOLD_EMPTY;
      end else begin
         cur <= nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold    <= '0;
         hold_id <= '0;
         rr_ptr  <= '0;
      end else if (accept) begin
         hold    <= req_vec[win_idx];
         hold_id <= win_idx;
         rr_ptr  <= ptr_nxt;
      end
   end

endmodule
